// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), derived sync windows,
// and the control bundle carried alongside the pixel counts.
package vga_timing_pkg;

    localparam int C_TOTAL_COLS    = 800;
    localparam int C_TOTAL_ROWS    = 525;
    localparam int C_ACTIVE_COLS   = 640;
    localparam int C_ACTIVE_ROWS   = 480;
    localparam int C_H_FRONT_PORCH = 16;
    localparam int C_H_SYNC_WIDTH  = 96;
    localparam int C_V_FRONT_PORCH = 10;
    localparam int C_V_SYNC_WIDTH  = 2;
    localparam int C_VIDEO_LATENCY = 2;
    localparam int C_VIDEO_WIDTH   = 4;
    localparam int C_COUNT_WIDTH   = 10;

    // Sync pulse windows, inclusive on both ends.
    localparam int C_H_SYNC_START = C_ACTIVE_COLS + C_H_FRONT_PORCH;
    localparam int C_H_SYNC_END   = C_H_SYNC_START + C_H_SYNC_WIDTH - 1;
    localparam int C_V_SYNC_START = C_ACTIVE_ROWS + C_V_FRONT_PORCH;
    localparam int C_V_SYNC_END   = C_V_SYNC_START + C_V_SYNC_WIDTH - 1;

    // Per-pixel control bits that travel through the delay line together.
    typedef struct packed {
        logic hsync;   // active-low
        logic vsync;   // active-low
        logic active;  // pixel lies inside the visible area
    } vga_ctrl_t;

    // Value held by the pipeline while idle or in reset: no sync pulse, blanked.
    localparam vga_ctrl_t C_CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

    // True when a count lies in the inclusive window [lo, hi].
    function automatic logic in_window(input logic [C_COUNT_WIDTH-1:0] value,
                                       input int lo, input int hi);
        return (value >= C_COUNT_WIDTH'(lo)) && (value <= C_COUNT_WIDTH'(hi));
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset and synchronous clear,
// both of which load a parameterised idle value. DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int              WIDTH = 3,
    parameter int              DEPTH = 1,
    parameter logic [WIDTH-1:0] IDLE = '0
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Clear,
    input  logic [WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0] o_Data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_Data = i_Data;
        end else begin : g_stages
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift one stage per clock; reset and clear both flush to idle.
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= IDLE;
                end else if (i_Clear) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= IDLE;
                end else begin
                    stage_q[0] <= i_Data;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign o_Data = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_tx.sv
// VGA timing transmitter: pixel counters, frame bookkeeping, sync generation,
// and a delayed, blanked RGB path aligned to the syncs.
module vga_sync_tx
    import vga_timing_pkg::*;
#(
    parameter int c_TOTAL_COLS    = C_TOTAL_COLS,
    parameter int c_TOTAL_ROWS    = C_TOTAL_ROWS,
    parameter int c_ACTIVE_COLS   = C_ACTIVE_COLS,
    parameter int c_ACTIVE_ROWS   = C_ACTIVE_ROWS,
    parameter int c_H_FRONT_PORCH = C_H_FRONT_PORCH,
    parameter int c_H_SYNC_WIDTH  = C_H_SYNC_WIDTH,
    parameter int c_V_FRONT_PORCH = C_V_FRONT_PORCH,
    parameter int c_V_SYNC_WIDTH  = C_V_SYNC_WIDTH,
    parameter int c_VIDEO_LATENCY = C_VIDEO_LATENCY,
    parameter int c_VIDEO_WIDTH   = C_VIDEO_WIDTH
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Enable,
    input  logic [c_VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [c_VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [c_VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic [9:0]               o_Col_Count,
    output logic [9:0]               o_Row_Count,
    output logic                     o_Active,
    output logic                     o_Frame_Start,
    output logic [7:0]               o_Frame_Count,
    output logic                     o_HSync,
    output logic                     o_VSync,
    output logic [c_VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Blu_Video
);

    localparam int H_SYNC_START = c_ACTIVE_COLS + c_H_FRONT_PORCH;
    localparam int H_SYNC_END   = H_SYNC_START + c_H_SYNC_WIDTH - 1;
    localparam int V_SYNC_START = c_ACTIVE_ROWS + c_V_FRONT_PORCH;
    localparam int V_SYNC_END   = V_SYNC_START + c_V_SYNC_WIDTH - 1;

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       run_q;            // enabled on the previous edge
    logic       active_q, active_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q;

    vga_ctrl_t  ctrl_raw;
    vga_ctrl_t  ctrl_dly;

    logic                     hsync_q, vsync_q;
    logic [c_VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;

    // Next count: park at (0,0) while idle, restart at (0,0) on the first
    // enabled edge, otherwise advance with col wrap carrying into row.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (!i_Enable || !run_q) begin
            col_d = '0;
            row_d = '0;
        end else if (col_q == 10'(c_TOTAL_COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == 10'(c_TOTAL_ROWS - 1)) ? 10'd0 : row_q + 10'd1;
        end else begin
            col_d = col_q + 10'd1;
        end
        active_d      = i_Enable && (col_d < 10'(c_ACTIVE_COLS)) && (row_d < 10'(c_ACTIVE_ROWS));
        frame_start_d = i_Enable && (col_d == 10'd0) && (row_d == 10'd0);
    end

    // Count register and the flags derived from the same next count.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            col_q         <= '0;
            row_q         <= '0;
            run_q         <= 1'b0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            run_q         <= i_Enable;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Frames started since reset; held (not cleared) while idle.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            frame_count_q <= '0;
        end else if (frame_start_q) begin
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    // Raw syncs decoded from the current count; VSync only moves at col wrap
    // because the row register only moves there.
    always_comb begin
        ctrl_raw.hsync  = !in_window(col_q, H_SYNC_START, H_SYNC_END);
        ctrl_raw.vsync  = !in_window(row_q, V_SYNC_START, V_SYNC_END);
        ctrl_raw.active = active_q;
    end

    // L-1 stages here plus the output register below give L cycles total.
    vga_delay_line #(
        .WIDTH ($bits(vga_ctrl_t)),
        .DEPTH (c_VIDEO_LATENCY - 1),
        .IDLE  (C_CTRL_IDLE)
    ) u_delay (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Clear (!i_Enable),
        .i_Data  (ctrl_raw),
        .o_Data  (ctrl_dly)
    );

    // Output stage: syncs from the delay line, RGB captured from the core
    // and forced to zero whenever the delayed active flag is low.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
        end else if (!i_Enable) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
        end else begin
            hsync_q <= ctrl_dly.hsync;
            vsync_q <= ctrl_dly.vsync;
            red_q   <= ctrl_dly.active ? i_Red_Video : '0;
            grn_q   <= ctrl_dly.active ? i_Grn_Video : '0;
            blu_q   <= ctrl_dly.active ? i_Blu_Video : '0;
        end
    end

    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Active      = active_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Frame_Count = frame_count_q;
    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_Red_Video   = red_q;
    assign o_Grn_Video   = grn_q;
    assign o_Blu_Video   = blu_q;

endmodule

// File: tb/tb_vga_sync_tx.sv
// Bench for vga_sync_tx. Horizontal timing is the 640x480 default; the
// vertical timing is shortened (30 rows, 20 active, sync rows 23..24) so a
// full frame is 24000 cycles. k counts enabled edges, k=0 is count (0,0).
module tb_vga_sync_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] red_in, grn_in, blu_in;
    logic [9:0] col, row;
    logic       act, fs, hs, vs;
    logic [7:0] fc;
    logic [3:0] red_out, grn_out, blu_out;

    int n_vec  = 0;
    int n_miss = 0;
    int k_cur;
    int hs_low = 0;
    int vs_low = 0;
    int fs_cnt = 0;

    always #5 clk = ~clk;

    vga_sync_tx #(
        .c_TOTAL_ROWS    (30),
        .c_ACTIVE_ROWS   (20),
        .c_V_FRONT_PORCH (3),
        .c_V_SYNC_WIDTH  (2)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Enable      (en),
        .i_Red_Video   (red_in),
        .i_Grn_Video   (grn_in),
        .i_Blu_Video   (blu_in),
        .o_Col_Count   (col),
        .o_Row_Count   (row),
        .o_Active      (act),
        .o_Frame_Start (fs),
        .o_Frame_Count (fc),
        .o_HSync       (hs),
        .o_VSync       (vs),
        .o_Red_Video   (red_out),
        .o_Grn_Video   (grn_out),
        .o_Blu_Video   (blu_out)
    );

    typedef struct {
        int         k;
        logic [3:0] rgb_in;
        logic [9:0] col;
        logic [9:0] row;
        logic       act;
        logic       fs;
        logic [7:0] fc;
        logic       hs;
        logic       vs;
        logic [3:0] rgb_out;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input int k, input logic [3:0] rin, input int c, input int r,
                                input logic a, input logic f, input int fcnt,
                                input logic h, input logic v, input logic [3:0] rout);
        vec_t t;
        t.k = k; t.rgb_in = rin; t.col = 10'(c); t.row = 10'(r);
        t.act = a; t.fs = f; t.fc = 8'(fcnt); t.hs = h; t.vs = v; t.rgb_out = rout;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int r, input logic a,
                           input logic f, input int fcnt, input logic h, input logic v,
                           input logic [3:0] rout);
        chk({tag, " col"}, 32'(col), 32'(c));
        chk({tag, " row"}, 32'(row), 32'(r));
        chk({tag, " active"}, 32'(act), 32'(a));
        chk({tag, " frame_start"}, 32'(fs), 32'(f));
        chk({tag, " frame_count"}, 32'(fc), 32'(fcnt));
        chk({tag, " hsync"}, 32'(hs), 32'(h));
        chk({tag, " vsync"}, 32'(vs), 32'(v));
        chk({tag, " red"}, 32'(red_out), 32'(rout));
        chk({tag, " grn"}, 32'(grn_out), 32'(rout));
        chk({tag, " blu"}, 32'(blu_out), 32'(rout));
    endtask

    task automatic set_rgb(input logic [3:0] v);
        red_in = v;
        grn_in = v;
        blu_in = v;
    endtask

    // One clock edge, sampled 1 ns later; tallies pulse widths along the way.
    task automatic step();
        @(posedge clk);
        #1;
        k_cur++;
        if (k_cur >= 2 && k_cur <= 801 && hs == 1'b0) hs_low++;
        if (k_cur >= 2 && k_cur <= 24001 && vs == 1'b0) vs_low++;
        if (k_cur >= 0 && k_cur <= 23999 && fs == 1'b1) fs_cnt++;
    endtask

    initial begin
        //            k      in    col  row  act  fs  fc  hs  vs  out
        vecs[0]  = mk(0,     4'h5, 0,   0,   1,   1,  0,  1,  1,  4'h0);
        vecs[1]  = mk(1,     4'hA, 1,   0,   1,   0,  1,  1,  1,  4'h0);
        vecs[2]  = mk(2,     4'h3, 2,   0,   1,   0,  1,  1,  1,  4'h3);
        vecs[3]  = mk(641,   4'hC, 641, 0,   0,   0,  1,  1,  1,  4'hC);
        vecs[4]  = mk(642,   4'hF, 642, 0,   0,   0,  1,  1,  1,  4'h0);
        vecs[5]  = mk(657,   4'hF, 657, 0,   0,   0,  1,  1,  1,  4'h0);
        vecs[6]  = mk(658,   4'hF, 658, 0,   0,   0,  1,  0,  1,  4'h0);
        vecs[7]  = mk(753,   4'h9, 753, 0,   0,   0,  1,  0,  1,  4'h0);
        vecs[8]  = mk(754,   4'h9, 754, 0,   0,   0,  1,  1,  1,  4'h0);
        vecs[9]  = mk(800,   4'h6, 0,   1,   1,   0,  1,  1,  1,  4'h0);
        vecs[10] = mk(802,   4'h7, 2,   1,   1,   0,  1,  1,  1,  4'h7);
        vecs[11] = mk(8799,  4'h1, 799, 10,  0,   0,  1,  1,  1,  4'h0);
        vecs[12] = mk(8800,  4'h2, 0,   11,  1,   0,  1,  1,  1,  4'h0);
        vecs[13] = mk(15841, 4'hB, 641, 19,  0,   0,  1,  1,  1,  4'hB);
        vecs[14] = mk(16002, 4'hF, 2,   20,  0,   0,  1,  1,  1,  4'h0);
        vecs[15] = mk(18401, 4'hF, 1,   23,  0,   0,  1,  1,  1,  4'h0);
        vecs[16] = mk(18402, 4'hF, 2,   23,  0,   0,  1,  1,  0,  4'h0);
        vecs[17] = mk(20001, 4'hF, 1,   25,  0,   0,  1,  1,  0,  4'h0);
        vecs[18] = mk(20002, 4'hF, 2,   25,  0,   0,  1,  1,  1,  4'h0);
        vecs[19] = mk(23999, 4'hF, 799, 29,  0,   0,  1,  1,  1,  4'h0);
        vecs[20] = mk(24000, 4'h8, 0,   0,   1,   1,  1,  1,  1,  4'h0);
        vecs[21] = mk(24002, 4'hD, 2,   0,   1,   0,  2,  1,  1,  4'hD);

        // Clock/reset: hold reset across edges with live colour on the inputs.
        rst = 1'b1;
        en  = 1'b0;
        set_rgb(4'hF);
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 1, 1, 4'h0);

        // Release reset and enable together; the next edge is k=0.
        rst   = 1'b0;
        en    = 1'b1;
        k_cur = -1;

        foreach (vecs[i]) begin
            while (k_cur < vecs[i].k) begin
                if (k_cur + 1 == vecs[i].k) set_rgb(vecs[i].rgb_in);
                step();
            end
            chk_all($sformatf("vec%0d k=%0d", i, vecs[i].k), vecs[i].col, vecs[i].row,
                    vecs[i].act, vecs[i].fs, vecs[i].fc, vecs[i].hs, vecs[i].vs,
                    vecs[i].rgb_out);
        end

        chk("hsync low cycles line0", 32'(hs_low), 32'd96);
        chk("vsync low cycles frame0", 32'(vs_low), 32'd1600);
        chk("frame_start pulses frame0", 32'(fs_cnt), 32'd1);

        // Enable dropped for 5 cycles mid-line: idle outputs, frame count held.
        set_rgb(4'hF);
        while (k_cur < 24300) step();
        chk_all("pre-idle", 300, 0, 1, 0, 2, 1, 1, 4'hF);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("idle%0d", i), 0, 0, 0, 0, 2, 1, 1, 4'h0);
        end
        en = 1'b1;
        step();
        chk_all("re-enable edge0", 0, 0, 1, 1, 2, 1, 1, 4'h0);
        step();
        chk_all("re-enable edge1", 1, 0, 1, 0, 3, 1, 1, 4'h0);

        // Asynchronous reset mid-frame at count (300,12).
        repeat (12 * 800 + 300 - 1) step();
        chk_all("pre-reset", 300, 12, 1, 0, 3, 1, 1, 4'hF);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async reset", 0, 0, 0, 0, 0, 1, 1, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk_all("post-reset edge0", 0, 0, 1, 1, 0, 1, 1, 4'h0);
        step();
        chk_all("post-reset edge1", 1, 0, 1, 0, 1, 1, 1, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
